// File: rtl/posit_pkg.sv
// Shared types and helpers for the posit decode path.
//   N_DEF / ES_DEF : default posit width and exponent-field width
//   scale_width()  : width of the combined scale k*2^ES + exp
//   posit_dec_t    : decoded posit record at the default configuration
package posit_pkg;

    localparam int unsigned N_DEF  = 8;
    localparam int unsigned ES_DEF = 3;
    localparam int unsigned RS_DEF = $clog2(N_DEF);

    function automatic int unsigned scale_width(input int unsigned n, input int unsigned es);
        return $clog2(n) + es + 1;
    endfunction

    localparam int unsigned SW_DEF = scale_width(N_DEF, ES_DEF);

    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic                     nar;
        logic signed [RS_DEF:0]   k;
        logic [ES_DEF-1:0]        exp;
        logic signed [SW_DEF-1:0] scale;
        logic [N_DEF-1:0]         frac;
    } posit_dec_t;

endpackage

// File: rtl/posit_regime_lzd.sv
// Regime run detector for a posit body (sign bit already stripped/negated).
//   body    : N-1 bit body, MSB first
//   run_bit : value of the leading run (body[N-2])
//   run_len : length of the leading run of identical bits, 1..N-1
module posit_regime_lzd #(
    parameter int unsigned N = 8
) (
    input  logic [N-2:0]         body,
    output logic                 run_bit,
    output logic [$clog2(N)-1:0] run_len
);

    localparam int unsigned LenW   = $clog2(N);
    localparam logic [LenW-1:0] LenOne = 1;

    logic stop;

    always_comb begin
        run_bit = body[N-2];
        run_len = '0;
        stop    = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (body[i] == run_bit)) begin
                run_len = run_len + LenOne;
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit decoder with valid/ready handshake.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake, in_posit is the N-bit posit word
//   out_valid/out_ready   : output handshake
//   out_sign/zero/nar     : sign and special-value flags
//   out_k, out_exp        : regime value and exponent field (zero-filled when truncated)
//   out_scale             : k*2^ES + exp
//   out_frac              : {hidden 1, fraction left-aligned}
//   nar_seen / nar_clear  : sticky NaR-delivered flag and its synchronous clear
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned ES = ES_DEF,
    parameter int unsigned RS = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_posit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic                          out_zero,
    output logic                          out_nar,
    output logic signed [RS:0]            out_k,
    output logic [((ES > 0) ? ES : 1)-1:0] out_exp,
    output logic signed [RS+ES:0]         out_scale,
    output logic [N-1:0]                  out_frac,
    output logic                          nar_seen,
    input  logic                          nar_clear
);

    // ES = 0 still carries a 1-bit exponent port, tied to zero.
    localparam int unsigned EW = (ES > 0) ? ES : 1;
    localparam int unsigned SW = RS + ES + 1;
    localparam logic [RS:0] KOne = 1;

    // Stage 1: sign, negated body and special flags.
    logic         s1_valid, s1_sign, s1_zero, s1_nar;
    logic [N-2:0] s1_body;
    logic [N-2:0] in_body;
    logic         s2_load;

    assign s2_load  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_load;
    assign in_body  = in_posit[N-2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_body  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_posit[N-1];
                s1_zero <= (in_posit == '0);
                s1_nar  <= (in_posit == {1'b1, {(N-1){1'b0}}});
                s1_body <= in_posit[N-1] ? -in_body : in_body;
            end
        end
    end

    // Stage 2 combinational decode.
    logic                   run_bit;
    logic [$clog2(N)-1:0]   run_len;
    logic [RS:0]            m_ext;
    logic [RS:0]            shamt;
    logic [N-2+EW:0]        ext;
    logic signed [RS:0]     k_d;
    logic [EW-1:0]          exp_d;
    logic signed [SW-1:0]   k_sx;
    logic [SW-1:0]          scale_d;
    logic [N-1:0]           frac_d;
    logic                   special;

    posit_regime_lzd #(
        .N (N)
    ) u_lzd (
        .body    (s1_body),
        .run_bit (run_bit),
        .run_len (run_len)
    );

    always_comb begin
        special = s1_zero | s1_nar;
        m_ext   = (RS+1)'(run_len);
        // Consume the run plus its terminator; shifting past the end zero-fills.
        shamt   = m_ext + KOne;
        ext     = {s1_body, {EW{1'b0}}} << shamt;
        k_d     = run_bit ? $signed(m_ext - KOne) : -$signed(m_ext);
        exp_d   = (ES > 0) ? ext[N-2+EW -: EW] : '0;
        k_sx    = SW'(k_d);
        scale_d = (k_sx <<< ES) + SW'(exp_d);
        frac_d  = {1'b1, ext[N-2+EW-ES -: N-1]};
        if (special) begin
            k_d     = '0;
            exp_d   = '0;
            scale_d = '0;
            frac_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
            out_k     <= '0;
            out_exp   <= '0;
            out_scale <= '0;
            out_frac  <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign;
                out_zero  <= s1_zero;
                out_nar   <= s1_nar;
                out_k     <= k_d;
                out_exp   <= exp_d;
                out_scale <= $signed(scale_d);
                out_frac  <= frac_d;
            end
        end
    end

    // Setting has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nar_seen <= 1'b0;
        end else if (out_valid && out_ready && out_nar) begin
            nar_seen <= 1'b1;
        end else if (nar_clear) begin
            nar_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_posit_decode_pipe.sv
module tb_posit_decode_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [7:0]        in_posit;
    logic              out_sign, out_zero, out_nar, nar_seen, nar_clear;
    logic signed [3:0] out_k;
    logic [2:0]        out_exp;
    logic signed [6:0] out_scale;
    logic [7:0]        out_frac;

    posit_decode_pipe #(.N(8), .ES(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_nar   (out_nar),
        .out_k     (out_k),
        .out_exp   (out_exp),
        .out_scale (out_scale),
        .out_frac  (out_frac),
        .nar_seen  (nar_seen),
        .nar_clear (nar_clear)
    );

    // Second configuration: N=16, ES=1.
    logic              v16, rdy16, ov16, or16, s16, z16, n16, ns16;
    logic [15:0]       p16, f16;
    logic signed [4:0] k16;
    logic [0:0]        e16;
    logic signed [5:0] sc16;

    posit_decode_pipe #(.N(16), .ES(1)) u_dut16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v16),
        .in_ready  (rdy16),
        .in_posit  (p16),
        .out_valid (ov16),
        .out_ready (or16),
        .out_sign  (s16),
        .out_zero  (z16),
        .out_nar   (n16),
        .out_k     (k16),
        .out_exp   (e16),
        .out_scale (sc16),
        .out_frac  (f16),
        .nar_seen  (ns16),
        .nar_clear (1'b0)
    );

    typedef struct {
        logic       sign;
        logic       zero;
        logic       nar;
        int         k;
        int         e;
        int         scale;
        logic [7:0] frac;
    } exp_t;

    typedef struct {
        logic [7:0] w;
        exp_t       x;
    } row_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];
    int   acc_cnt = 0;
    int   pop_cnt = 0;
    logic sticky  = 1'b0;

    // Independent bit-walking reference decode for N=8, ES=3.
    function automatic exp_t ref_dec(input logic [7:0] p);
        exp_t r;
        int   b, pos, m, e;
        logic rb, run;
        r = '{sign: 1'b0, zero: 1'b0, nar: 1'b0, k: 0, e: 0, scale: 0, frac: 8'h00};
        if (p == 8'h00) begin
            r.zero = 1'b1;
            return r;
        end
        if (p == 8'h80) begin
            r.nar  = 1'b1;
            r.sign = 1'b1;
            return r;
        end
        r.sign = p[7];
        b   = p[7] ? ((128 - int'(p[6:0])) & 127) : int'(p[6:0]);
        rb  = b[6];
        m   = 0;
        pos = 6;
        run = 1'b1;
        while (run) begin
            if (pos >= 0 && b[pos] == rb) begin
                m++;
                pos--;
            end else begin
                run = 1'b0;
            end
        end
        if (pos >= 0) pos--;
        r.k = rb ? m - 1 : -m;
        e = 0;
        for (int i = 0; i < 3; i++) begin
            e = e * 2 + ((pos >= 0) ? int'(b[pos]) : 0);
            if (pos >= 0) pos--;
        end
        r.e     = e;
        r.scale = r.k * 8 + e;
        r.frac  = 8'h80;
        for (int j = 6; j >= 0; j--) begin
            if (pos >= 0) begin
                r.frac[j] = b[pos];
                pos--;
            end
        end
        return r;
    endfunction

    function automatic exp_t dut_now();
        exp_t d;
        d.sign  = out_sign;
        d.zero  = out_zero;
        d.nar   = out_nar;
        d.k     = int'(out_k);
        d.e     = int'(out_exp);
        d.scale = int'(out_scale);
        d.frac  = out_frac;
        return d;
    endfunction

    function automatic row_t mk(input logic [7:0] w, input logic s, input logic z,
                                input logic n, input int k, input int e, input int sc,
                                input logic [7:0] f);
        row_t r;
        r.w = w;
        r.x = '{sign: s, zero: z, nar: n, k: k, e: e, scale: sc, frac: f};
        return r;
    endfunction

    task automatic chk_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic chk_dec(input string name, input exp_t a, input exp_t r);
        total++;
        if (a.sign !== r.sign || a.zero !== r.zero || a.nar !== r.nar || a.k != r.k ||
            a.e != r.e || a.scale != r.scale || a.frac !== r.frac) begin
            bad++;
            $display("FAIL %s: got s%0d z%0d n%0d k%0d e%0d sc%0d f%h want s%0d z%0d n%0d k%0d e%0d sc%0d f%h",
                     name, a.sign, a.zero, a.nar, a.k, a.e, a.scale, a.frac,
                     r.sign, r.zero, r.nar, r.k, r.e, r.scale, r.frac);
        end
    endtask

    // One clock cycle: drive, settle, score transfers, advance to just after the next edge.
    task automatic step(input logic v, input logic [7:0] w, input logic r);
        in_valid  = v;
        in_posit  = w;
        out_ready = r;
        #1;
        if (out_valid && out_ready) begin
            pop_cnt++;
            chk_int("out_has_pending", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) chk_dec("stream", dut_now(), sbq.pop_front());
        end
        if (in_valid && in_ready) begin
            sbq.push_back(ref_dec(w));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    row_t       tbl[9];
    logic [7:0] wl[4];
    exp_t       snap;
    int         idx, guard, a0;
    logic       v;
    logic [7:0] w;

    initial begin
        tbl[0] = mk(8'h40, 0, 0, 0,  0, 0,   0, 8'h80);
        tbl[1] = mk(8'h53, 0, 0, 0,  0, 4,   4, 8'hE0);
        tbl[2] = mk(8'h7F, 0, 0, 0,  6, 0,  48, 8'h80);
        tbl[3] = mk(8'h01, 0, 0, 0, -6, 0, -48, 8'h80);
        tbl[4] = mk(8'hAD, 1, 0, 0,  0, 4,   4, 8'hE0);
        tbl[5] = mk(8'h28, 0, 0, 0, -1, 2,  -6, 8'h80);
        tbl[6] = mk(8'hC0, 1, 0, 0,  0, 0,   0, 8'h80);
        tbl[7] = mk(8'h00, 0, 1, 0,  0, 0,   0, 8'h00);
        tbl[8] = mk(8'h80, 1, 0, 1,  0, 0,   0, 8'h00);
        wl[0] = 8'h40; wl[1] = 8'h53; wl[2] = 8'h7F; wl[3] = 8'h01;

        reset = 1'b1; in_valid = 1'b0; in_posit = '0; out_ready = 1'b0; nar_clear = 1'b0;
        v16 = 1'b0; p16 = '0; or16 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_in_ready", int'(in_ready), 1);
        chk_int("rst_nar_seen", int'(nar_seen), 0);
        chk_int("rst_frac", int'(out_frac), 0);
        @(posedge clk);
        #1;

        // Single decodes, 2-cycle latency.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].w, 1'b1);
            chk_int($sformatf("lat1_valid[%0d]", i), int'(out_valid), 0);
            step(1'b0, 8'h00, 1'b1);
            chk_int($sformatf("lat2_valid[%0d]", i), int'(out_valid), 1);
            chk_dec($sformatf("tbl[%0d]", i), dut_now(), tbl[i].x);
            chk_int($sformatf("nar_seen_pre[%0d]", i), int'(nar_seen), int'(sticky));
            step(1'b0, 8'h00, 1'b1);
            if (tbl[i].x.nar) sticky = 1'b1;
            chk_int($sformatf("nar_seen_post[%0d]", i), int'(nar_seen), int'(sticky));
            chk_int($sformatf("drained[%0d]", i), int'(out_valid), 0);
        end

        nar_clear = 1'b1;
        @(posedge clk);
        #1 nar_clear = 1'b0;
        chk_int("nar_clear", int'(nar_seen), 0);

        // Set and clear in the same cycle: set wins.
        step(1'b1, 8'h80, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        nar_clear = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        nar_clear = 1'b0;
        chk_int("nar_set_wins", int'(nar_seen), 1);

        // Back-pressure.
        acc_cnt = 0; pop_cnt = 0; idx = 0;
        for (int c = 0; c < 4; c++) begin
            a0 = acc_cnt;
            step(1'b1, wl[idx], 1'b0);
            if (acc_cnt != a0) idx++;
            if (c == 1) snap = dut_now();
        end
        chk_int("bp_accepted", acc_cnt, 2);
        chk_int("bp_in_ready", int'(in_ready), 0);
        chk_int("bp_out_valid", int'(out_valid), 1);
        chk_dec("bp_hold", dut_now(), snap);
        chk_dec("bp_first", dut_now(), tbl[0].x);
        guard = 0;
        while (pop_cnt < 4 && guard < 20) begin
            v = (idx < 4);
            a0 = acc_cnt;
            step(v, v ? wl[idx] : 8'h00, 1'b1);
            if (acc_cnt != a0) idx++;
            guard++;
        end
        chk_int("bp_popped", pop_cnt, 4);
        chk_int("bp_sb_empty", sbq.size(), 0);

        // Random stress.
        acc_cnt = 0; guard = 0;
        while (acc_cnt < 1000 && guard < 20000) begin
            w = 8'($urandom);
            if ($urandom_range(0, 7) == 0) w = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h80;
            step(($urandom_range(0, 1) == 1), w, ($urandom_range(0, 3) != 0));
            guard++;
        end
        guard = 0;
        while (sbq.size() > 0 && guard < 20) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        chk_int("rand_accepted", acc_cnt, 1000);
        chk_int("rand_sb_empty", sbq.size(), 0);

        // Reset with both stages full.
        step(1'b1, 8'h80, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h53, 1'b0);
        chk_int("pre_rst_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_int("mid_rst_out_valid", int'(out_valid), 0);
        chk_int("mid_rst_in_ready", int'(in_ready), 1);
        chk_int("mid_rst_nar_seen", int'(nar_seen), 0);
        sbq.delete();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk_int("post_rst_empty", int'(out_valid), 0);
        pop_cnt = 0;
        step(1'b1, 8'h53, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk_dec("post_rst_dec", dut_now(), tbl[1].x);
        step(1'b0, 8'h00, 1'b1);
        chk_int("post_rst_pop", pop_cnt, 1);

        // N=16, ES=1.
        v16 = 1'b1; p16 = 16'h7FFF; or16 = 1'b1;
        #1;
        chk_int("n16_in_ready", int'(rdy16), 1);
        @(posedge clk);
        #1 v16 = 1'b0;
        @(posedge clk);
        #1;
        chk_int("n16_valid", int'(ov16), 1);
        chk_int("n16_k", int'(k16), 14);
        chk_int("n16_exp", int'(e16), 0);
        chk_int("n16_scale", int'(sc16), 28);
        chk_int("n16_frac", int'(f16), 32768);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
